// File: rtl/stream_aligner.sv
// Multi-channel aligning input buffer: one circular FIFO per channel, all channels popped
// together into a registered valid/ready output stage once every channel has a sample.
module stream_aligner #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic                     overwrite_i,
    input  logic                     flush_i,
    output logic [NUM_CH*DATA_W-1:0] out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH-1:0]        full_o,
    output logic [NUM_CH-1:0]        empty_o,
    output logic [NUM_CH*LVL_W-1:0]  level_o,
    output logic [15:0]              drop_cnt_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned DROP_SUM_W = $clog2(NUM_CH + 1);
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
    logic [LVL_W-1:0] count_q  [NUM_CH];
    logic [LVL_W-1:0] count_d  [NUM_CH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] ovw;
    logic [NUM_CH-1:0] drop;
    logic              all_avail;
    logic              pop;

    logic                     out_valid_q;
    logic                     out_valid_d;
    logic [NUM_CH*DATA_W-1:0] out_data_q;
    logic [NUM_CH*DATA_W-1:0] out_data_d;

    logic [15:0]           drop_cnt_q;
    logic [15:0]           drop_cnt_d;
    logic [DROP_SUM_W-1:0] drop_num;
    logic [16:0]           drop_sum;

    // Status flags come straight from the registered counts.
    always_comb begin
        full_o  = '0;
        empty_o = '0;
        level_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full_o[c]                  = (count_q[c] == LvlFull);
            empty_o[c]                 = (count_q[c] == '0);
            level_o[c*LVL_W +: LVL_W]  = count_q[c];
        end
    end

    always_comb begin
        all_avail = &(~empty_o);
        pop       = all_avail && (!out_valid_q || out_ready_i) && !flush_i;
    end

    // A full channel still accepts a write when the lockstep pop frees a slot this cycle.
    always_comb begin
        push = '0;
        ovw  = '0;
        drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (flush_i) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end else begin
                if (in_valid_i[c]) begin
                    if (!full_o[c] || pop) begin
                        push[c] = 1'b1;
                    end else begin
                        drop[c] = 1'b1;
                        ovw[c]  = overwrite_i;
                    end
                end
                if (push[c] || ovw[c]) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
                end
                if (pop || ovw[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
                end
                count_d[c] = count_q[c] + LVL_W'(push[c]) - LVL_W'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c] || ovw[c]) begin
                mem_q[c][wr_ptr_q[c]] <= in_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (pop) begin
            out_valid_d = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                out_data_d[c*DATA_W +: DATA_W] = mem_q[c][rd_ptr_q[c]];
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Drops from several channels in one cycle add together; the total saturates.
    always_comb begin
        drop_num = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drop_num = drop_num + DROP_SUM_W'(drop[c]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_num);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_stream_aligner.sv
// Randomised and directed bench for stream_aligner, checked every cycle against a queue model.
module tb_stream_aligner;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCH   = 2;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_valid;
    logic              overwrite;
    logic              flush;
    logic              out_ready;
    logic [NCH*DW-1:0] out_data;
    logic              out_valid;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH*LW-1:0] level;
    logic [15:0]       drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: one queue per channel, an output register and a drop total.
    logic [DW-1:0]     mq [NCH][$];
    logic              m_valid;
    logic [NCH*DW-1:0] m_data;
    int unsigned       m_drop;
    logic [DW-1:0]     got [$];

    always #5 clk = ~clk;

    stream_aligner #(
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .NUM_CH(NCH),
        .LVL_W (LW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .overwrite_i(overwrite),
        .flush_i    (flush),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level),
        .drop_cnt_o (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit avail;
        bit do_pop;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_drop  = 0;
            return;
        end
        if (flush) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_valid = 1'b0;
            return;
        end
        avail = 1'b1;
        for (int c = 0; c < NCH; c++) if (mq[c].size() == 0) avail = 1'b0;
        do_pop = avail && (!m_valid || out_ready);
        if (do_pop) begin
            for (int c = 0; c < NCH; c++) m_data[c*DW +: DW] = mq[c].pop_front();
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (in_valid[c]) begin
                if (mq[c].size() < DEPTH) begin
                    mq[c].push_back(in_data[c*DW +: DW]);
                end else begin
                    m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                    if (overwrite) begin
                        void'(mq[c].pop_front());
                        mq[c].push_back(in_data[c*DW +: DW]);
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NCH-1:0]    e_full;
            logic [NCH-1:0]    e_empty;
            logic [NCH*LW-1:0] e_level;
            e_full  = '0;
            e_empty = '0;
            e_level = '0;
            for (int c = 0; c < NCH; c++) begin
                e_full[c]            = (mq[c].size() == DEPTH);
                e_empty[c]           = (mq[c].size() == 0);
                e_level[c*LW +: LW]  = LW'(mq[c].size());
            end
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("out_data", 64'(out_data), 64'(m_data));
            check("full", 64'(full), 64'(e_full));
            check("empty", 64'(empty), 64'(e_empty));
            check("level", 64'(level), 64'(e_level));
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = '0;
        in_data   = '0;
        overwrite = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    task automatic put(input logic [NCH-1:0] v, input logic [DW-1:0] k);
        in_valid = v;
        in_data  = {k, k};
        tick();
    endtask

    task automatic fill5(input logic ovw);
        out_ready = 1'b0;
        overwrite = ovw;
        for (int k = 1; k <= 5; k++) put(2'b11, DW'(k));
        in_valid = '0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        in_valid  = '0;
        got.delete();
        for (int i = 0; i < n; i++) begin
            if (out_valid) got.push_back(out_data[DW-1:0]);
            tick();
        end
    endtask

    task automatic check_got(input string name, input int e0, input int e1, input int e2,
                             input int e3, input int e4);
        int exp_v [5];
        logic [DW-1:0] v;
        exp_v = '{e0, e1, e2, e3, e4};
        check({name, "_len"}, 64'(got.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            v = (i < got.size()) ? got[i] : 'x;
            check(name, 64'(v), 64'(exp_v[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        do_reset();
        tick();

        // Basic alignment: ch1 arrives two cycles after ch0.
        out_ready = 1'b1;
        in_valid = 2'b01; in_data = 32'h0000_0011; tick();
        in_valid = 2'b00; tick();
        in_valid = 2'b10; in_data = 32'h0022_0000; tick();
        in_valid = 2'b00;
        check("align_wait", 64'(out_valid), 64'd0);
        tick();
        check("align_valid", 64'(out_valid), 64'd1);
        check("align_data", 64'(out_data), 64'h0022_0011);
        check("align_level", 64'(level), 64'd0);
        tick();

        // Drop-newest under backpressure.
        do_reset();
        fill5(1'b0);
        put(2'b11, 16'd6);
        in_valid = '0;
        check("dn_drop", 64'(drop_cnt), 64'd2);
        check("dn_full", 64'(full), 64'b11);
        check("dn_level", 64'(level), 64'b100_100);
        check("dn_head", 64'(out_data), 64'h0001_0001);
        drain(10);
        check_got("dn_order", 1, 2, 3, 4, 5);

        // Overwrite-oldest.
        do_reset();
        fill5(1'b1);
        put(2'b11, 16'd6);
        in_valid = '0;
        check("ow_drop", 64'(drop_cnt), 64'd2);
        drain(10);
        check_got("ow_order", 1, 3, 4, 5, 6);

        // Full FIFOs with a simultaneous pop and write.
        do_reset();
        fill5(1'b0);
        check("fp_full", 64'(full), 64'b11);
        out_ready = 1'b1;
        put(2'b11, 16'd6);
        in_valid = '0;
        check("fp_valid", 64'(out_valid), 64'd1);
        check("fp_data", 64'(out_data), 64'h0002_0002);
        check("fp_level", 64'(level), 64'b100_100);
        check("fp_drop", 64'(drop_cnt), 64'd0);
        tick();
        check("fp_next", 64'(out_data), 64'h0003_0003);
        check("fp_level2", 64'(level), 64'b011_011);

        // Flush with levels {3,1} and a pending output.
        do_reset();
        put(2'b11, 16'd1);
        put(2'b11, 16'd2);
        put(2'b01, 16'd3);
        put(2'b01, 16'd4);
        check("fl_pre_level", 64'(level), 64'b001_011);
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        put(2'b11, 16'd9);
        flush = 1'b0; in_valid = '0;
        check("fl_level", 64'(level), 64'd0);
        check("fl_empty", 64'(empty), 64'b11);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_drop", 64'(drop_cnt), 64'd0);
        check("fl_data", 64'(out_data), 64'h0001_0001);
        tick();
        check("fl_ignored", 64'(out_valid), 64'd0);

        // Randomised traffic with occasional flush and reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = NCH'($urandom_range(0, 3));
            in_data   = $urandom;
            overwrite = 1'($urandom_range(0, 1));
            case ((i / 200) % 3)
                0:       out_ready = ($urandom_range(0, 3) == 0);
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            flush = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
            tick();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        // Drop counter saturation, flush immunity, then reset mid-stream.
        do_reset();
        fill5(1'b0);
        in_valid = 2'b11;
        for (int i = 0; i < 40000 && m_drop < 32'hFFFE; i++) begin
            overwrite = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            tick();
        end
        check("sat_near", 64'(drop_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) tick();
        check("sat_max", 64'(drop_cnt), 64'hFFFF);
        in_valid = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_flush", 64'(drop_cnt), 64'hFFFF);
        put(2'b11, 16'h55);
        put(2'b11, 16'h66);
        in_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_empty", 64'(empty), 64'b11);
        check("rst_level", 64'(level), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
